// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: PC ownership, credit-based imem requests, in-order instruction buffer.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_cnt output counting instructions accepted by decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] out_cnt_r;
    logic [CW-1:0] disc_cnt_r;
    logic [CW-1:0] fifo_cnt_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] tag_wr_r;
    logic [AW-1:0] tag_rd_r;
    logic [31:0]   data_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r   [FIFO_DEPTH];
    logic [31:0]   tag_mem_r  [FIFO_DEPTH];

    logic [CW:0]   credit_sum_s;
    logic          grant_s;
    logic          rsp_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] out_next_s;
    logic          unused_s;

    assign unused_s = ^redirect_pc[1:0];

    // Credits: every buffered word and every in-flight request holds one FIFO slot.
    assign credit_sum_s = {1'b0, fifo_cnt_r} + {1'b0, out_cnt_r};
    assign imem_req     = !rst && (credit_sum_s < DEPTH_C);
    assign imem_addr    = fetch_pc_r;
    assign grant_s      = imem_req && imem_gnt;
    assign rsp_s        = imem_rvalid && (out_cnt_r != CNT_ZERO);
    assign drop_s       = rsp_s && (disc_cnt_r != CNT_ZERO);
    assign push_s       = rsp_s && !drop_s;
    assign instr_valid  = (fifo_cnt_r != CNT_ZERO);
    assign pop_s        = instr_valid && instr_ready;
    assign instr        = data_mem_r[rd_ptr_r];
    assign instr_pc     = pc_mem_r[rd_ptr_r];

    // Outstanding count after this cycle's grant and response.
    always_comb begin
        out_next_s = out_cnt_r;
        if (grant_s && !rsp_s) begin
            out_next_s = out_cnt_r + CNT_ONE;
        end else if (!grant_s && rsp_s) begin
            out_next_s = out_cnt_r - CNT_ONE;
        end else begin
            out_next_s = out_cnt_r;
        end
    end

    // Fetch PC: redirect wins over the sequential increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC & ~32'd3;
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[31:2], 2'b00};
        end else if (grant_s) begin
            fetch_pc_r <= fetch_pc_r + 32'd4;
        end
    end

    // In-flight and to-be-discarded response counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_r  <= CNT_ZERO;
            disc_cnt_r <= CNT_ZERO;
        end else begin
            out_cnt_r <= out_next_s;
            if (redirect_valid) begin
                disc_cnt_r <= out_next_s;
            end else if (drop_s) begin
                disc_cnt_r <= disc_cnt_r - CNT_ONE;
            end
        end
    end

    // PC tags of in-flight requests; discarded responses retire their tag too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_r <= PTR_ZERO;
            tag_rd_r <= PTR_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_r[i] <= 32'd0;
            end
        end else begin
            if (grant_s) begin
                tag_mem_r[tag_wr_r] <= fetch_pc_r;
                tag_wr_r            <= tag_wr_r + PTR_ONE;
            end
            if (rsp_s) begin
                tag_rd_r <= tag_rd_r + PTR_ONE;
            end
        end
    end

    // Instruction buffer; a redirect drops everything including this cycle's push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            fifo_cnt_r <= CNT_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'd0;
                pc_mem_r[i]   <= 32'd0;
            end
        end else if (redirect_valid) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            fifo_cnt_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= tag_mem_r[tag_rd_r];
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Accepted-instruction counter; survives redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
        end else if (pop_s) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule
